win_seq_ctrl: RTL

- Sequences the 8-bit pixel stream into the window shift-register buffer and drives its write enable.
- Tracks the image row and column, and flags when the buffer holds a complete WIN_ROWS x WIN_COLS window.
- Hands each complete window to the downstream texture-feature stage with a valid/ready handshake, then signals end of frame.

---
 rtl/win_seq_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/win_seq_ctrl.sv
// Window sequencer: streams pixels into the window buffer, tracks row/col and hands off complete windows.
// Optional abort input enabled by defining WIN_SEQ_ABORT_EN.
module win_seq_ctrl #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int WIN_ROWS = 6,
    parameter int WIN_COLS = 9,
    parameter int CW       = $clog2(IMG_W),
    parameter int RW       = $clog2(IMG_H)
) (
    input  logic          i_clk,
    input  logic          in_rst,
    input  logic          i_start,
`ifdef WIN_SEQ_ABORT_EN
    input  logic          i_abort,
`endif
    input  logic          i_pix_valid,
    input  logic [7:0]    i_pix,
    output logic          o_pix_ready,
    output logic          o_wren,
    output logic [7:0]    o_data,
    output logic          o_win_valid,
    input  logic          i_win_ready,
    output logic [RW-1:0] o_win_row,
    output logic [CW-1:0] o_win_col,
    output logic [15:0]   o_win_cnt,
    output logic          o_busy,
    output logic          o_done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(WIN_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(WIN_ROWS - 1);

    logic [1:0]    r_state;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_win_valid;
    logic [RW-1:0] r_win_row;
    logic [CW-1:0] r_win_col;
    logic [15:0]   r_win_cnt;
    logic          r_abort_done;

    logic w_abort;
    logic w_acc;
    logic w_hs;
    logic w_qual;
    logic w_col_wrap;
    logic w_last;
    logic w_drain_exit;

`ifdef WIN_SEQ_ABORT_EN
    assign w_abort = i_abort & (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // Abort wins over both pixel acceptance and the window handshake.
    assign o_pix_ready  = (r_state == S_ACTIVE) & ~w_abort & (~r_win_valid | i_win_ready);
    assign w_acc        = o_pix_ready & i_pix_valid;
    assign w_hs         = r_win_valid & i_win_ready & ~w_abort;
    assign w_qual       = w_acc & (r_row >= ROW_MIN) & (r_col >= COL_MIN);
    assign w_col_wrap   = (r_col == COL_LAST);
    assign w_last       = w_acc & w_col_wrap & (r_row == ROW_LAST);
    assign w_drain_exit = (r_state == S_DRAIN) & ~w_abort & (~r_win_valid | i_win_ready);

    assign o_wren      = w_acc;
    assign o_data      = i_pix;
    assign o_win_valid = r_win_valid;
    assign o_win_row   = r_win_row;
    assign o_win_col   = r_win_col;
    assign o_win_cnt   = r_win_cnt;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = w_drain_exit | r_abort_done;

    always_ff @(posedge i_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_win_valid  <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_win_cnt    <= '0;
            r_abort_done <= 1'b0;
        end else begin
            r_abort_done <= w_abort;
            if (w_abort) begin
                r_state     <= S_IDLE;
                r_row       <= '0;
                r_col       <= '0;
                r_win_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_state   <= S_ACTIVE;
                            r_row     <= '0;
                            r_col     <= '0;
                            r_win_cnt <= '0;
                        end
                    end
                    S_ACTIVE: begin
                        if (w_last) r_state <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (w_drain_exit) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase

                if (w_acc) begin
                    if (w_col_wrap) begin
                        r_col <= '0;
                        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end

                // A new window arriving in the handshake cycle replaces the one leaving.
                if (w_qual) begin
                    r_win_valid <= 1'b1;
                    r_win_row   <= r_row;
                    r_win_col   <= r_col;
                end else if (w_hs) begin
                    r_win_valid <= 1'b0;
                end

                if (w_hs && (r_win_cnt != 16'hFFFF)) r_win_cnt <= r_win_cnt + 16'd1;
            end
        end
    end

endmodule
